dtree_frame_driver: RTL
=======================

# dtree_frame_driver

Sequential front/back end for the generated combinational decision-tree classifier. It accepts a byte-serial feature frame over a valid/ready stream, assembles the parallel feature bus that drives the tree, and waits a fixed settling time. It then captures the tree's class output and returns it over a second valid/ready stream. The tree itself stays outside this block because it is regenerated per training seed.

## Interface
- NUM_FEAT, 7: feature bytes per frame, indices 0..NUM_FEAT-1.
- FEAT_W, 8: bits per feature.
- CLASS_W, 2: width of the class result.
- KEEP_MASK, 7'b1110011: bit i=1 means feature i is registered onto the bus; bit i=0 means the byte is consumed and discarded, and that bus slice stays 0.
- EVAL_CYCLES, 1: settling cycles allowed for the tree before capture (1..15).
- clk, in, 1: clock.
- rst, in, 1: reset. Asynchronous, active-high.
- s_valid, in, 1: feature byte valid.
- s_ready, out, 1: block can accept a byte.
- s_data, in, FEAT_W: feature byte. Frames arrive in index order, feature 0 first.
- s_last, in, 1: marks the final byte of a frame.
- feat_bus, out, NUM_FEAT*FEAT_W: feature i on bits [i*FEAT_W +: FEAT_W]; drives the tree's X inputs.
- class_in, in, CLASS_W: combinational class from the tree.
- m_valid, out, 1: result valid.
- m_ready, in, 1: downstream accepts the result.
- m_class, out, CLASS_W: registered class.
- err_frame, out, 1: one-cycle pulse on a malformed frame.

## Operation
- States are LOAD, DRAIN, EVAL and OUT. Reset enters LOAD.
- A transfer occurs when s_valid && s_ready. s_ready = 1 in LOAD and DRAIN, 0 otherwise.
- **LOAD**
  - Each transfer writes s_data to slice idx if KEEP_MASK[idx] is set, then increments idx.
  - Transfer with idx==NUM_FEAT-1 and s_last=1: idx←0, state→EVAL, eval counter←0.
  - Transfer with idx<NUM_FEAT-1 and s_last=1 (short frame): err_frame pulses, idx←0, feat_bus is cleared to 0, state stays LOAD.
  - Transfer with idx==NUM_FEAT-1 and s_last=0 (long frame): err_frame pulses, idx←0, feat_bus is cleared, state→DRAIN.
- **DRAIN**: consume bytes without writing. A transfer with s_last=1 returns to LOAD. err_frame does not pulse again.
- **EVAL**
  - The eval counter increments each cycle.
  - When the counter reaches EVAL_CYCLES-1: m_class←class_in, m_valid←1, state→OUT.
- **OUT**: hold m_valid and m_class until m_ready=1. Then m_valid←0 and state→LOAD on the next edge.
- feat_bus is stable from frame completion through the end of OUT. It is overwritten only by the next frame's transfers.
- Counters: idx is clog2(NUM_FEAT) bits and never exceeds NUM_FEAT-1. The eval counter is 4 bits.

## Timing
- Reset values: s_ready=1, m_valid=0, m_class=0, feat_bus=0, err_frame=0, idx=0.
- Reset asserted mid-frame or mid-OUT discards all state immediately. Any pending result is lost.
- Latency: the edge accepting the last byte enters EVAL. m_valid rises EVAL_CYCLES edges later. With default EVAL_CYCLES=1, m_valid is high in the 2nd cycle after the final transfer cycle.
- A feature slice updates on the edge of its transfer. The tree sees the complete frame no later than the first EVAL cycle.
- Minimum frame period is NUM_FEAT + EVAL_CYCLES + 1 cycles when m_ready is held high.
- m_valid holds without glitch under m_ready backpressure; s_ready stays 0 for the whole stall.
- s_valid while s_ready=0 is ignored, with no data loss in the upstream contract.
- err_frame is registered and asserts on the edge after the offending transfer.

## Structure
- A shared package dtree_pkg holds:
  - the state enum (LOAD, DRAIN, EVAL, OUT);
  - the localparam default for KEEP_MASK;
  - the FEAT_W and CLASS_W defaults shared with the tree generator.
- No sub-module. The FSM, idx counter and eval counter are inline.
- The generated tree instance is connected by the parent: feat_bus slices to X0..X6 and its out to class_in.

## Test plan
- **Nominal frame**: bytes 0x10,0x20,0x30,0x40,0x50,0x60,0x70 with s_last on the 7th, class_in=2'd3, m_ready=1.
  - Slices 0,1,4,5,6 = 0x10,0x20,0x50,0x60,0x70; slices 2,3 = 0.
  - m_valid rises 2 cycles after the last transfer with m_class=3, then returns to 0 for one cycle.
- **Short frame**: s_last on the 4th byte -> err_frame pulses once, feat_bus=0, s_ready remains 1. The next 7-byte frame yields a result normally.
- **Long frame**: 9 bytes with s_last on the 9th -> err_frame pulses after byte 7. Bytes 8-9 are consumed in DRAIN, no m_valid is produced, and the next frame is classified correctly.
- **Backpressure**: hold m_ready=0 for 10 cycles -> m_valid and m_class are stable, s_ready=0 throughout, and the next frame is accepted only after the handshake.
- **Settling**: with EVAL_CYCLES=4, change class_in from 1 to 2 in the 3rd EVAL cycle -> m_class=2, captured exactly 4 cycles after the last byte.
- **Async reset**: assert rst after byte 3 and again during OUT -> all outputs return to reset values immediately, and a full frame afterwards classifies correctly.

Source files
------------

// File: rtl/dtree_pkg.sv
// dtree_pkg
// Shared definitions for the decision-tree frame driver and the tree
// generator: the driver FSM state encoding and the default frame geometry.
// Ports: none (package only).
package dtree_pkg;

    // Driver FSM states: collect a frame, discard the tail of an over-long
    // frame, let the tree settle, and hold the result for the consumer.
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        EVAL  = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Frame geometry shared with the generated tree. Features 2 and 3 are
    // not used by the current tree, so their slices are never loaded.
    localparam int             NUM_FEAT_DEF  = 7;
    localparam int             FEAT_W_DEF    = 8;
    localparam int             CLASS_W_DEF   = 2;
    localparam logic [6:0]     KEEP_MASK_DEF = 7'b1110011;

endpackage

// File: rtl/dtree_frame_driver.sv
// dtree_frame_driver
// Sequential wrapper around the external combinational decision tree.
// A byte-serial feature frame is collected over a valid/ready stream into a
// parallel feature bus, the tree is given EVAL_CYCLES cycles to settle, and
// its class output is captured and offered on a second valid/ready stream.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_valid/s_ready     feature byte handshake
//   s_data, s_last      feature byte, end-of-frame marker
//   feat_bus            parallel features, feature i at [i*FEAT_W +: FEAT_W]
//   class_in            combinational class from the tree
//   m_valid/m_ready     result handshake
//   m_class             registered class result
//   err_frame           one-cycle pulse on a short or long frame
module dtree_frame_driver
    import dtree_pkg::*;
#(
    parameter int                   NUM_FEAT    = NUM_FEAT_DEF,
    parameter int                   FEAT_W      = FEAT_W_DEF,
    parameter int                   CLASS_W     = CLASS_W_DEF,
    parameter logic [NUM_FEAT-1:0]  KEEP_MASK   = KEEP_MASK_DEF,
    parameter int                   EVAL_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [FEAT_W-1:0]          s_data,
    input  logic                       s_last,
    output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
    input  logic [CLASS_W-1:0]         class_in,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [CLASS_W-1:0]         m_class,
    output logic                       err_frame
);

    localparam int              IDX_W     = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_FEAT - 1);
    localparam logic [3:0]       EVAL_LAST = 4'(EVAL_CYCLES - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [3:0]       eval_cnt;
    logic             xfer;

    // A byte is taken whenever upstream offers one while we are ready.
    assign xfer = s_valid && s_ready;

    // Single FSM with all outputs registered. s_ready is updated together
    // with every state change so it is high exactly in LOAD and DRAIN.
    // On a malformed frame the whole bus is cleared after the slice write,
    // so the later non-blocking clear wins over the write of that byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            s_ready   <= 1'b1;
            idx       <= '0;
            eval_cnt  <= '0;
            feat_bus  <= '0;
            m_valid   <= 1'b0;
            m_class   <= '0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= 1'b0;
            case (state)
                LOAD: begin
                    if (xfer) begin
                        for (int i = 0; i < NUM_FEAT; i++) begin
                            if (KEEP_MASK[i] && (idx == IDX_W'(i))) begin
                                feat_bus[i*FEAT_W +: FEAT_W] <= s_data;
                            end
                        end
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (s_last) begin
                                state    <= EVAL;
                                s_ready  <= 1'b0;
                                eval_cnt <= '0;
                            end else begin
                                err_frame <= 1'b1;
                                feat_bus  <= '0;
                                state     <= DRAIN;
                            end
                        end else if (s_last) begin
                            err_frame <= 1'b1;
                            feat_bus  <= '0;
                            idx       <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer && s_last) begin
                        state <= LOAD;
                    end
                end
                EVAL: begin
                    if (eval_cnt == EVAL_LAST) begin
                        m_class <= class_in;
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end else begin
                        eval_cnt <= eval_cnt + 4'd1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= LOAD;
                    end
                end
                default: begin
                    state   <= LOAD;
                    s_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
